load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port req_valid, input, 1, requester holds a request.
REQ-004 SHALL have port req_ready, output, 1, unit accepts a request this cycle.
REQ-005 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-006 SHALL have port req_size, input, [0:1]; 00 = byte, 01 = half (2 bytes), 10 = word (6 bytes), 11 = reserved.
REQ-007 SHALL have port req_adr, input, [0:11], byte address.
REQ-008 SHALL have port req_wdata, input, [0:47], store data, right-justified for byte and half.
REQ-009 SHALL have port resp_valid, output, 1, response held.
REQ-010 SHALL have port resp_ready, input, 1, consumer takes the response.
REQ-011 SHALL have port resp_data, output, [0:47], load result, zero-extended, right-justified.
REQ-012 SHALL have port resp_err, output, 1, request rejected and no memory access made.
REQ-013 SHALL have ports memwrite and memread, outputs, 1 each; mem_adr, output, [0:11]; write_data, output, [0:47]; mem_word, input, [0:47]; memory read data is combinational and valid in the same cycle memread and mem_adr are driven.

Function
REQ-014 SHALL use FSM states IDLE, READ, WRITE, RESP, with one transaction in flight.
REQ-015 SHALL drive req_ready=1 only in IDLE, and SHALL latch size, address, data and direction on req_valid && req_ready.
REQ-016 SHALL route an accepted request as follows: error goes to RESP with resp_err=1; word store goes to WRITE; any load or sub-word store goes to READ.
REQ-017 SHALL, in READ, drive memread=1 with mem_adr equal to the latched address for exactly one cycle and capture mem_word at that cycle's edge; a load then goes to RESP and a store goes to WRITE.
REQ-018 SHALL, in WRITE, drive memwrite=1 for exactly one cycle; write_data SHALL be req_wdata for a word, {req_wdata[40:47], captured[8:47]} for a byte, and {req_wdata[32:47], captured[16:47]} for a half; the next state is RESP.
REQ-019 SHALL place a byte load at resp_data[40:47]=captured[0:7], a half load at resp_data[32:47]=captured[0:15], and a word load as the full captured word; all other bits SHALL be 0.
REQ-020 SHALL, in RESP, hold resp_valid=1 with stable resp_data and resp_err until resp_ready=1, then return to IDLE on the next cycle with no same-cycle bypass.
REQ-021 SHALL make resp_valid rise 2 cycles after acceptance for a load or word store, and 3 cycles after acceptance for a sub-word store.
REQ-022 SHALL treat req_size=11 as an error in all builds.
REQ-023 SHALL keep memread=memwrite=0 outside READ and WRITE, and SHALL never assert both together.
REQ-024 SHALL return resp_data=0 for stores and for errors.

Reset
REQ-025 SHALL, on rst_n=0, immediately enter IDLE and force memread=0, memwrite=0, resp_valid=0, resp_err=0, resp_data=0, mem_adr=0, write_data=0 and req_ready=0; an in-flight transaction SHALL be discarded.
REQ-026 SHALL assert req_ready one cycle after rst_n deasserts.

Configuration
REQ-027 SHALL implement macro LSU_BOUNDS_CHECK_EN: when it is defined, any request with adr + 5 > 1023 (evaluated in 13 bits) SHALL be an error with no memory access; when it is undefined, there is no range check and the address passes through truncated to 12 bits.

Verification
REQ-028 SHALL cover: mem[0x010..0x015]=11..66, word load at 0x010 -> resp_data=0x112233445566, err=0, 2 cycles after acceptance.
REQ-029 SHALL cover: byte store 0xAB at 0x010 with resp_ready held 0 for 3 cycles -> a READ then a WRITE with write_data=0xAB2233445566; resp_valid held stable 3 cycles.
REQ-030 SHALL cover: half load at 0x011 -> resp_data=0x000000002233.
REQ-031 SHALL cover: req_size=11, or (with LSU_BOUNDS_CHECK_EN) word load at 0x3FB -> resp_err=1, memread and memwrite never asserted; 0x3FA is accepted without error.
REQ-032 SHALL cover: rst_n pulsed low during WRITE -> memwrite drops immediately, no RESP occurs, req_ready=1 one cycle after release.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Requester-side request/response handshake bundle for the load/store unit.
// master = requester, slave = load_store_unit.
interface load_store_unit_if;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [0:1]   req_size;
    logic [0:11]  req_adr;
    logic [0:47]  req_wdata;
    logic         resp_valid;
    logic         resp_ready;
    logic [0:47]  resp_data;
    logic         resp_err;

    modport master (
        output req_valid, req_write, req_size, req_adr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_adr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-transaction load/store unit: byte/half/6-byte-word accesses, sub-word stores via read-merge-write.
// Optional macro LSU_BOUNDS_CHECK_EN rejects any request whose 6-byte window would pass address 1023.
module load_store_unit (
    input  logic                 clk,
    input  logic                 rst_n,
    load_store_unit_if.slave     req_bus,
    output logic                 memwrite,
    output logic                 memread,
    output logic [0:11]          mem_adr,
    output logic [0:47]          write_data,
    input  logic [0:47]          mem_word
);

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 48;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t        state;
    logic          write_q;
    logic [1:0]    size_q;
    logic [0:AW-1] adr_q;
    logic [0:15]   wdata_q;
    logic          req_err_c;
    logic          accept_c;

    // Merge right-justified store data into the most-significant bytes of the fetched word.
    function automatic logic [0:DW-1] merge_store(input logic [1:0] sz, input logic [0:15] wd,
                                                  input logic [0:DW-1] word);
        if (sz == SZ_BYTE) return {wd[8:15], word[8:DW-1]};
        else               return {wd, word[16:DW-1]};
    endfunction

    function automatic logic [0:DW-1] load_result(input logic [1:0] sz, input logic [0:DW-1] word);
        case (sz)
            SZ_BYTE: return {40'd0, word[0:7]};
            SZ_HALF: return {32'd0, word[0:15]};
            default: return word;
        endcase
    endfunction

    assign accept_c = req_bus.req_valid && req_bus.req_ready;

`ifdef LSU_BOUNDS_CHECK_EN
    assign req_err_c = (req_bus.req_size == SZ_RSVD) ||
                       ((13'({1'b0, req_bus.req_adr}) + 13'd5) > 13'd1023);
`else
    assign req_err_c = (req_bus.req_size == SZ_RSVD);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            write_q            <= 1'b0;
            size_q             <= SZ_BYTE;
            adr_q              <= '0;
            wdata_q            <= '0;
            memread            <= 1'b0;
            memwrite           <= 1'b0;
            mem_adr            <= '0;
            write_data         <= '0;
            req_bus.req_ready  <= 1'b0;
            req_bus.resp_valid <= 1'b0;
            req_bus.resp_err   <= 1'b0;
            req_bus.resp_data  <= '0;
        end else begin
            // Memory strobes are single-cycle pulses; the bus idles at zero.
            memread           <= 1'b0;
            memwrite          <= 1'b0;
            mem_adr           <= '0;
            write_data        <= '0;
            req_bus.req_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        write_q <= req_bus.req_write;
                        size_q  <= req_bus.req_size;
                        adr_q   <= req_bus.req_adr;
                        wdata_q <= req_bus.req_wdata[32:47];
                        if (req_err_c) begin
                            state              <= RESP;
                            req_bus.resp_valid <= 1'b1;
                            req_bus.resp_err   <= 1'b1;
                            req_bus.resp_data  <= '0;
                        end else if (req_bus.req_write && req_bus.req_size == SZ_WORD) begin
                            state      <= WRITE;
                            memwrite   <= 1'b1;
                            mem_adr    <= req_bus.req_adr;
                            write_data <= req_bus.req_wdata;
                        end else begin
                            state   <= READ;
                            memread <= 1'b1;
                            mem_adr <= req_bus.req_adr;
                        end
                    end else begin
                        req_bus.req_ready <= 1'b1;
                    end
                end
                READ: begin
                    if (write_q) begin
                        state      <= WRITE;
                        memwrite   <= 1'b1;
                        mem_adr    <= adr_q;
                        write_data <= merge_store(size_q, wdata_q, mem_word);
                    end else begin
                        state              <= RESP;
                        req_bus.resp_valid <= 1'b1;
                        req_bus.resp_err   <= 1'b0;
                        req_bus.resp_data  <= load_result(size_q, mem_word);
                    end
                end
                WRITE: begin
                    state              <= RESP;
                    req_bus.resp_valid <= 1'b1;
                    req_bus.resp_err   <= 1'b0;
                    req_bus.resp_data  <= '0;
                end
                RESP: begin
                    if (req_bus.resp_ready) begin
                        state              <= IDLE;
                        req_bus.resp_valid <= 1'b0;
                        req_bus.resp_err   <= 1'b0;
                        req_bus.resp_data  <= '0;
                        req_bus.req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte-addressed memory model.
// Expected values for the LSU_BOUNDS_CHECK_EN build follow the same macro.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memwrite, memread;
    logic [0:11] mem_adr;
    logic [0:47] write_data;
    logic [0:47] mem_word;
    logic [7:0]  mem [0:4095];

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int both_cnt = 0;
    int resp_cnt = 0;
    logic [47:0] last_wdata = '0;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_bus    (bus.slave),
        .memwrite   (memwrite),
        .memread    (memread),
        .mem_adr    (mem_adr),
        .write_data (write_data),
        .mem_word   (mem_word)
    );

    always #5 clk = ~clk;

    // Combinational 6-byte read, most-significant byte at the lowest address.
    assign mem_word = {mem[mem_adr], mem[12'(mem_adr + 12'd1)], mem[12'(mem_adr + 12'd2)],
                       mem[12'(mem_adr + 12'd3)], mem[12'(mem_adr + 12'd4)], mem[12'(mem_adr + 12'd5)]};

    always @(posedge clk) begin
        if (memwrite) begin
            for (int i = 0; i < 6; i++) mem[12'(mem_adr + 12'(i))] = write_data[8*i +: 8];
        end
    end

    always @(negedge clk) begin
        if (memread)  rd_cnt++;
        if (memwrite) begin wr_cnt++; last_wdata = write_data; end
        if (memread && memwrite) both_cnt++;
        if (bus.resp_valid) resp_cnt++;
    end

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, stall the response for 'hold' cycles, then consume it.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic [11:0] adr,
                          input logic [47:0] wd, input int hold, output int lat,
                          output logic [47:0] data, output logic err, output logic stable);
        logic ok;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
        bus.req_adr = adr; bus.req_wdata = wd;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus.req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("accept_timeout", 48'(ok), 48'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        ok = 1'b0; lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.resp_valid) begin ok = 1'b1; lat = n; break; end
        end
        check("resp_timeout", 48'(ok), 48'd1);
        data = bus.resp_data; err = bus.resp_err; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.resp_valid || bus.resp_data !== data || bus.resp_err !== err) stable = 1'b0;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        check("resp_drop", 48'(bus.resp_valid), 48'd0);
    endtask

    task automatic run(input string tag, input logic wr, input logic [1:0] sz, input logic [11:0] adr,
                       input logic [47:0] wd, input int hold, input logic [47:0] exp_data,
                       input logic exp_err, input int exp_lat, input int exp_rd, input int exp_wr);
        int lat, rd0, wr0;
        logic [47:0] data;
        logic err, stable;
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(wr, sz, adr, wd, hold, lat, data, err, stable);
        check({tag, "_data"}, data, exp_data);
        check({tag, "_err"}, 48'(err), 48'(exp_err));
        check({tag, "_lat"}, 48'(lat), 48'(exp_lat));
        check({tag, "_reads"}, 48'(rd_cnt - rd0), 48'(exp_rd));
        check({tag, "_writes"}, 48'(wr_cnt - wr0), 48'(exp_wr));
        if (hold > 0) check({tag, "_stable"}, 48'(stable), 48'd1);
    endtask

    initial begin
        int resp0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h010] = 8'h11; mem[12'h011] = 8'h22; mem[12'h012] = 8'h33;
        mem[12'h013] = 8'h44; mem[12'h014] = 8'h55; mem[12'h015] = 8'h66;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_adr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;

        // Reset state
        #23;
        check("rst_req_ready", 48'(bus.req_ready), 48'd0);
        check("rst_resp_valid", 48'(bus.resp_valid), 48'd0);
        check("rst_resp_err", 48'(bus.resp_err), 48'd0);
        check("rst_resp_data", bus.resp_data, 48'd0);
        check("rst_mem_strobes", 48'({memread, memwrite}), 48'd0);
        check("rst_mem_adr", 48'(mem_adr), 48'd0);
        check("rst_write_data", write_data, 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_ready_before_edge", 48'(bus.req_ready), 48'd0);
        @(negedge clk);
        check("rel_ready_after_edge", 48'(bus.req_ready), 48'd1);

        run("word_load",   1'b0, 2'b10, 12'h010, 48'h0,            0, 48'h112233445566, 1'b0, 2, 1, 0);
        run("byte_store",  1'b1, 2'b00, 12'h010, 48'h0000000000AB, 3, 48'h0,            1'b0, 3, 1, 1);
        check("byte_store_wdata", last_wdata, 48'hAB2233445566);
        run("word_reload", 1'b0, 2'b10, 12'h010, 48'h0,            0, 48'hAB2233445566, 1'b0, 2, 1, 0);
        run("half_load",   1'b0, 2'b01, 12'h011, 48'h0,            0, 48'h000000002233, 1'b0, 2, 1, 0);
        run("byte_load",   1'b0, 2'b00, 12'h012, 48'h0,            0, 48'h000000000033, 1'b0, 2, 1, 0);
        run("half_store",  1'b1, 2'b01, 12'h020, 48'hFFFFFFFFBEEF, 0, 48'h0,            1'b0, 3, 1, 1);
        check("half_store_wdata", last_wdata, 48'hBEEF00000000);
        run("word_store",  1'b1, 2'b10, 12'h030, 48'h123456789ABC, 1, 48'h0,            1'b0, 2, 0, 1);
        run("word_load30", 1'b0, 2'b10, 12'h030, 48'h0,            0, 48'h123456789ABC, 1'b0, 2, 1, 0);
        run("size_rsvd",   1'b0, 2'b11, 12'h010, 48'h0,            2, 48'h0,            1'b1, 1, 0, 0);
        run("rsvd_store",  1'b1, 2'b11, 12'h010, 48'hFFFFFFFFFFFF, 0, 48'h0,            1'b1, 1, 0, 0);
        run("adr_3fa",     1'b0, 2'b10, 12'h3FA, 48'h0,            0, 48'h0,            1'b0, 2, 1, 0);
`ifdef LSU_BOUNDS_CHECK_EN
        run("adr_3fb",     1'b0, 2'b10, 12'h3FB, 48'h0,            0, 48'h0,            1'b1, 1, 0, 0);
        run("byte_3ff",    1'b1, 2'b00, 12'h3FF, 48'h0000000000CC, 0, 48'h0,            1'b1, 1, 0, 0);
`else
        run("adr_3fb",     1'b0, 2'b10, 12'h3FB, 48'h0,            0, 48'h0,            1'b0, 2, 1, 0);
        run("adr_fff",     1'b0, 2'b01, 12'hFFF, 48'h0,            0, 48'h0,            1'b0, 2, 1, 0);
`endif

        // Reset pulsed while the unit is writing
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
        bus.req_adr = 12'h040; bus.req_wdata = 48'hCAFEF00D1234;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("wr_memwrite_high", 48'(memwrite), 48'd1);
        resp0 = resp_cnt;
        #1 rst_n = 1'b0;
        #1;
        check("wr_rst_memwrite", 48'(memwrite), 48'd0);
        check("wr_rst_write_data", write_data, 48'd0);
        check("wr_rst_req_ready", 48'(bus.req_ready), 48'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("wr_rel_req_ready", 48'(bus.req_ready), 48'd1);
        check("wr_no_resp", 48'(resp_cnt - resp0), 48'd0);
        run("wr_discarded", 1'b0, 2'b10, 12'h040, 48'h0, 0, 48'h0, 1'b0, 2, 1, 0);

        check("never_both_strobes", 48'(both_cnt), 48'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
